// File: rtl/simple_neuron_if.sv
// Bus bundle for the two-input neuron: operand side (in_valid, pixels,
// weights, bias) and result side (products, total, activation, out_valid).
interface simple_neuron_if #(
    parameter int DATA_W = 20
);
    logic                       in_valid;
    logic signed [DATA_W-1:0]   pixel1;
    logic signed [DATA_W-1:0]   pixel2;
    logic signed [DATA_W-1:0]   weight1;
    logic signed [DATA_W-1:0]   weight2;
    logic signed [DATA_W-1:0]   bias;
    logic signed [2*DATA_W-1:0] product1;
    logic signed [2*DATA_W-1:0] product2;
    logic signed [2*DATA_W-1:0] total;
    logic signed [2*DATA_W-1:0] activation;
    logic                       out_valid;

    // Producer of operands / consumer of results
    modport master (
        output in_valid, pixel1, pixel2, weight1, weight2, bias,
        input  product1, product2, total, activation, out_valid
    );

    // The neuron itself
    modport slave (
        input  in_valid, pixel1, pixel2, weight1, weight2, bias,
        output product1, product2, total, activation, out_valid
    );
endinterface

// File: rtl/simple_neuron.sv
// Two-input fixed-point perceptron: p1*w1 + p2*w2 + bias, saturated to the
// product width, followed by ReLU. Two register stages: operand capture,
// then result capture. One input set per clock, no backpressure.
module simple_neuron #(
    parameter int DATA_W = 20,
    parameter int FRAC_W = 10
) (
    input logic           clk,
    input logic           rst_n,
    simple_neuron_if.slave bus
);
    localparam int PROD_W = 2 * DATA_W;
    // Two guard bits: sum of three PROD_W-bit signed terms cannot overflow.
    localparam int SUM_W  = PROD_W + 2;

    localparam logic signed [SUM_W-1:0] SAT_MAX = {3'b000, {(PROD_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN = {3'b111, {(PROD_W-1){1'b0}}};

    // Stage-1 operand registers
    logic                     r_valid;
    logic signed [DATA_W-1:0] r_pixel1;
    logic signed [DATA_W-1:0] r_pixel2;
    logic signed [DATA_W-1:0] r_weight1;
    logic signed [DATA_W-1:0] r_weight2;
    logic signed [DATA_W-1:0] r_bias;

    // Stage-2 result registers
    logic                     r_out_valid;
    logic signed [PROD_W-1:0] r_product1;
    logic signed [PROD_W-1:0] r_product2;
    logic signed [PROD_W-1:0] r_total;
    logic signed [PROD_W-1:0] r_activation;

    // Combinational datapath between the stages
    logic signed [PROD_W-1:0] w_pix1_ext;
    logic signed [PROD_W-1:0] w_pix2_ext;
    logic signed [PROD_W-1:0] w_wt1_ext;
    logic signed [PROD_W-1:0] w_wt2_ext;
    logic signed [PROD_W-1:0] w_prod1;
    logic signed [PROD_W-1:0] w_prod2;
    logic signed [PROD_W-1:0] w_bias_al;
    logic signed [SUM_W-1:0]  w_sum;
    logic signed [PROD_W-1:0] w_total;
    logic signed [PROD_W-1:0] w_act;

    // Capture operands; the valid bit always advances so idle cycles become bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_pixel1  <= '0;
            r_pixel2  <= '0;
            r_weight1 <= '0;
            r_weight2 <= '0;
            r_bias    <= '0;
        end else begin
            r_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_pixel1  <= bus.pixel1;
                r_pixel2  <= bus.pixel2;
                r_weight1 <= bus.weight1;
                r_weight2 <= bus.weight2;
                r_bias    <= bus.bias;
            end
        end
    end

    // Sign-extend operands to full product width so the products are exact.
    assign w_pix1_ext = PROD_W'(r_pixel1);
    assign w_pix2_ext = PROD_W'(r_pixel2);
    assign w_wt1_ext  = PROD_W'(r_weight1);
    assign w_wt2_ext  = PROD_W'(r_weight2);
    assign w_prod1    = w_pix1_ext * w_wt1_ext;
    assign w_prod2    = w_pix2_ext * w_wt2_ext;

    // Bias moves from FRAC_W to 2*FRAC_W fractional bits to line up with the products.
    assign w_bias_al  = PROD_W'(r_bias) <<< FRAC_W;

    assign w_sum = SUM_W'(w_prod1) + SUM_W'(w_prod2) + SUM_W'(w_bias_al);

    // Clamp the wide sum into the product range, then apply ReLU
    always_comb begin
        w_total = w_sum[PROD_W-1:0];
        if (w_sum > SAT_MAX) begin
            w_total = SAT_MAX[PROD_W-1:0];
        end else if (w_sum < SAT_MIN) begin
            w_total = SAT_MIN[PROD_W-1:0];
        end
        w_act = '0;
        if (!w_total[PROD_W-1] && (w_total != '0)) begin
            w_act = w_total;
        end
    end

    // Register results; data holds across bubbles, out_valid follows stage-1 valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_product1   <= '0;
            r_product2   <= '0;
            r_total      <= '0;
            r_activation <= '0;
        end else begin
            r_out_valid <= r_valid;
            if (r_valid) begin
                r_product1   <= w_prod1;
                r_product2   <= w_prod2;
                r_total      <= w_total;
                r_activation <= w_act;
            end
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.product1   = r_product1;
    assign bus.product2   = r_product2;
    assign bus.total      = r_total;
    assign bus.activation = r_activation;
endmodule

// File: tb/tb_simple_neuron.sv
// Bench for simple_neuron: a scoreboard queue fed at drive time and drained
// by a result monitor, plus per-scenario tasks with their own inline checks.
module tb_simple_neuron;
    localparam int DW = 20;
    localparam int PW = 40;

    logic clk;
    logic rst_n;

    simple_neuron_if #(.DATA_W(DW)) bus ();

    simple_neuron #(.DATA_W(DW), .FRAC_W(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [PW-1:0] p1;
        logic [PW-1:0] p2;
        logic [PW-1:0] tot;
        logic [PW-1:0] act;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model in 64-bit integer arithmetic
    function automatic exp_t model(input logic signed [DW-1:0] p1, w1, p2, w2, b);
        longint a1, a2, s;
        exp_t   e;
        a1 = longint'(p1) * longint'(w1);
        a2 = longint'(p2) * longint'(w2);
        s  = a1 + a2 + longint'(b) * 1024;
        if (s > 64'sh7F_FFFF_FFFF)       s = 64'sh7F_FFFF_FFFF;
        else if (s < -64'sh80_0000_0000) s = -64'sh80_0000_0000;
        e.p1  = a1[PW-1:0];
        e.p2  = a2[PW-1:0];
        e.tot = s[PW-1:0];
        e.act = (s > 0) ? s[PW-1:0] : '0;
        return e;
    endfunction

    // Drive one cycle of stimulus; accepted inputs push their expected result
    task automatic drive(input logic v, input logic [DW-1:0] p1, w1, p2, w2, b);
        @(posedge clk);
        #1;
        bus.in_valid = v;
        bus.pixel1   = p1;
        bus.weight1  = w1;
        bus.pixel2   = p2;
        bus.weight2  = w2;
        bus.bias     = b;
        if (v) sb.push_back(model(p1, w1, p2, w2, b));
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, '0, '0, '0);
    endtask

    // Bounded wait for all expected results to come out
    task automatic drain(input string name);
        int n;
        idle();
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got %0d pending results required 0", name, sb.size());
            sb.delete();
        end
    endtask

    // Result monitor: pop and compare on every out_valid
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL mon_unexpected out_valid got 1 required 0 (total=%h)", bus.total);
            end else begin
                e = sb.pop_front();
                txn++;
                $display("txn %0d p1=%h p2=%h total=%h act=%h", txn,
                         bus.product1, bus.product2, bus.total, bus.activation);
                checks += 3;
                if (bus.product1 !== e.p1) begin
                    errors++;
                    $display("FAIL mon_product1 got %h required %h", bus.product1, e.p1);
                end
                if (bus.product2 !== e.p2) begin
                    errors++;
                    $display("FAIL mon_product2 got %h required %h", bus.product2, e.p2);
                end
                if (bus.total !== e.tot) begin
                    errors++;
                    $display("FAIL mon_total got %h required %h", bus.total, e.tot);
                end
                if (bus.activation !== e.act) begin
                    errors++;
                    $display("FAIL mon_activation got %h required %h", bus.activation, e.act);
                end
            end
        end
    end

    task automatic check_all_zero(input string name);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.product1 !== '0 || bus.product2 !== '0 ||
            bus.total !== '0 || bus.activation !== '0) begin
            errors++;
            $display("FAIL %s got v=%b p1=%h p2=%h tot=%h act=%h required all 0", name,
                     bus.out_valid, bus.product1, bus.product2, bus.total, bus.activation);
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.pixel1   = '0;
        bus.pixel2   = '0;
        bus.weight1  = '0;
        bus.weight2  = '0;
        bus.bias     = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("after_release");
    endtask

    task automatic test_negative();
        drive(1'b1, 20'hFF000, 20'h01000, 20'h0, 20'h0, 20'h0);
        drain("negative");
    endtask

    task automatic test_positive();
        drive(1'b1, 20'h0, 20'h0, 20'h00600, 20'h00800, 20'h00100);
        drain("positive");
    endtask

    task automatic test_saturation();
        drive(1'b1, 20'h80000, 20'h80000, 20'h80000, 20'h80000, 20'h7FFFF);
        drive(1'b1, 20'h80000, 20'h7FFFF, 20'h80000, 20'h7FFFF, 20'h80000);
        drive(1'b1, 20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 20'h7FFFF, 20'h7FFFF);
        drive(1'b1, 20'h00400, 20'hFFC00, 20'h0, 20'h0, 20'h00400);
        drain("saturation");
    endtask

    // Three back-to-back, one gap, one more: out_valid mirrors in_valid 2 cycles late
    task automatic test_back_to_back();
        logic          vld [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [DW-1:0] px1 [7] = '{20'h00C00, 20'hFF400, 20'h01800, 20'h0, 20'h00200, 20'h0, 20'h0};
        logic [DW-1:0] wt1 [7] = '{20'h00400, 20'h00800, 20'hFFE00, 20'h0, 20'h03000, 20'h0, 20'h0};
        logic [DW-1:0] px2 [7] = '{20'h00100, 20'h00A00, 20'h00300, 20'h0, 20'hFFF00, 20'h0, 20'h0};
        logic [DW-1:0] wt2 [7] = '{20'h00200, 20'h00400, 20'h00500, 20'h0, 20'h00100, 20'h0, 20'h0};
        logic [DW-1:0] bs  [7] = '{20'h00000, 20'hFFF00, 20'h00080, 20'h0, 20'h00010, 20'h0, 20'h0};
        exp_t held;
        held = model(px1[2], wt1[2], px2[2], wt2[2], bs[2]);
        for (int i = 0; i < 7; i++) begin
            drive(vld[i], px1[i], wt1[i], px2[i], wt2[i], bs[i]);
            @(negedge clk);
            if (i >= 2) begin
                checks++;
                if (bus.out_valid !== vld[i-2]) begin
                    errors++;
                    $display("FAIL b2b_valid step %0d got %b required %b", i, bus.out_valid, vld[i-2]);
                end
            end
            if (i == 5) begin
                checks++;
                if (bus.total !== held.tot || bus.product1 !== held.p1 || bus.activation !== held.act) begin
                    errors++;
                    $display("FAIL b2b_hold got tot=%h p1=%h act=%h required tot=%h p1=%h act=%h",
                             bus.total, bus.product1, bus.activation, held.tot, held.p1, held.act);
                end
            end
        end
        drain("back_to_back");
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            drive(($urandom_range(0, 3) != 0), DW'($urandom), DW'($urandom),
                  DW'($urandom), DW'($urandom), DW'($urandom));
        end
        drain("random");
    endtask

    // Accept an input, reset before it reaches the outputs
    task automatic test_reset_mid();
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.pixel1   = 20'h00400;
        bus.weight1  = 20'h00400;
        bus.pixel2   = 20'h00400;
        bus.weight2  = 20'h00400;
        bus.bias     = 20'h00400;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_mid_immediate");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_no_valid cycle %0d got %b required 0", i, bus.out_valid);
            end
        end
        check_all_zero("reset_mid_after");
    endtask

    initial begin
        test_reset();
        test_negative();
        test_positive();
        test_saturation();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/simple_neuron.md
# simple_neuron

Two-input fixed-point neuron (perceptron) datapath: multiplies two signed pixel values by two signed weights, adds a signed bias, and applies a ReLU activation. It is the basic compute element of the FPGA ML inference path, sitting between the pixel/weight fetch logic and the layer accumulator. It is fully pipelined: one input set is accepted per clock, and the result appears a fixed 2 cycles later.

## Interface
- DATA_W, 20, width of pixel/weight/bias inputs; signed two's complement.
- FRAC_W, 10, fractional bits of inputs (Q10.10 at default).
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  inputs below are valid this cycle.
- pixel1, pixel2  input  DATA_W  signed pixel operands, Q(DATA_W-FRAC_W).FRAC_W.
- weight1, weight2  input  DATA_W  signed weights, same format.
- bias  input  DATA_W  signed bias, same format.
- product1  output  2*DATA_W  registered pixel1*weight1, signed, 2*FRAC_W fractional bits.
- product2  output  2*DATA_W  registered pixel2*weight2, same format.
- total  output  2*DATA_W  registered product1+product2+bias, saturated, same format.
- activation  output  2*DATA_W  registered ReLU(total).
- out_valid  output  1  outputs above hold a new result this cycle.

## Operation
- Multiply: full-precision signed DATA_W x DATA_W -> 2*DATA_W; no rounding or truncation. Product format Q20.20 at defaults.
- Bias alignment: sign-extend bias to 2*DATA_W, then shift left by FRAC_W, so its binary point matches the products.
- Sum: compute product1 + product2 + aligned bias with at least 2*DATA_W+2 bits of precision.
- Saturation: if the sum exceeds the 2*DATA_W signed range, clamp total to max positive (0x7FFFFFFFFF at defaults) or max negative (0x8000000000). There is no wrap-around.
- Activation: activation = total if total > 0, else 0. Zero total gives 0.
- No backpressure. Every in_valid pulse produces exactly one out_valid pulse, in order.
- When in_valid is low, the pipeline stage carries an invalid bubble. The output data registers hold their last values and out_valid is 0.

## Timing
- Stage 1 (edge N, in_valid=1): capture pixel1/2, weight1/2, bias and the valid bit into input registers.
- Multipliers and the adder/saturation/ReLU logic are combinational from the stage-1 registers.
- Stage 2 (edge N+1): register product1, product2, total, activation, and out_valid=stage-1 valid.
- Latency: inputs sampled at edge N are visible on outputs after edge N+1. Throughput: 1 per cycle.
- Reset (rst_n low, any time, asynchronous):
  - all stage registers clear immediately;
  - product1, product2, total, activation = 0 and out_valid = 0;
  - in-flight data is discarded.
- First capture happens on the first rising edge with rst_n high.
- Outputs are stable for the entire cycle; only registered values are driven.

## Test plan
- Negative product: pixel1=0xFF000 (-4.0), weight1=0x01000 (4.0), pixel2=weight2=bias=0, in_valid=1 -> 2 cycles later: product1=0xFFFF000000 (-16.0), total=0xFFFF000000, activation=0, out_valid=1.
- Positive path: pixel2=0x00600 (1.5), weight2=0x00800 (2.0), bias=0x00100 (0.25), pixel1=weight1=0 -> product2=0x0000300000, total=activation=0x0000340000.
- Saturation: pixel1=pixel2=weight1=weight2=0x80000, bias=0x7FFFF -> product1=product2=0x4000000000, total=activation=0x7FFFFFFFFF. Negative clamp case: pixel1=pixel2=0x80000, weight1=weight2=0x7FFFF, bias=0x80000 -> total=0x8000000000, activation=0.
- Back-to-back: three consecutive in_valid cycles with distinct inputs -> three consecutive out_valid cycles with matching results in order. A one-cycle in_valid gap gives a one-cycle out_valid gap, and outputs hold their values during the gap.
- Reset mid-pipeline: assert rst_n low between edges N and N+1 after an accepted input -> all outputs read 0 immediately, and no out_valid follows after release.
